// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the multiply/divide controller.
package mdu_pkg;

    localparam int OP_W = 4;

    // EX-stage multiply/divide operation codes; codes 11..15 decode as no-ops.
    typedef enum logic [3:0] {
        NOP   = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MADD  = 4'd5,
        MADDU = 4'd6,
        MSUB  = 4'd7,
        MSUBU = 4'd8,
        MTHI  = 4'd9,
        MTLO  = 4'd10
    } mdu_op_t;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MUL_WAIT  = 2'd1,
        DIV_WAIT  = 2'd2,
        DIV_DRAIN = 2'd3
    } mdu_state_t;

    // How a finished product is folded into {HI,LO}.
    typedef enum logic [1:0] {
        ACC_LOAD = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_mode_t;

    // True for every op that is sent to the multiplier.
    function automatic logic is_mul_op(input mdu_op_t o);
        logic r;
        case (o)
            MULT, MULTU, MADD, MADDU, MSUB, MSUBU: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    // True for ops that are sent to the divider.
    function automatic logic is_div_op(input mdu_op_t o);
        logic r;
        case (o)
            DIV, DIVU: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the HI/LO move-to ops.
    function automatic logic is_mt_op(input mdu_op_t o);
        logic r;
        case (o)
            MTHI, MTLO: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the two's-complement flavours of multiply and divide.
    function automatic logic is_signed_op(input mdu_op_t o);
        logic r;
        case (o)
            MULT, MADD, MSUB, DIV: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    // Accumulation mode of a multiply-class op.
    function automatic acc_mode_t acc_mode(input mdu_op_t o);
        acc_mode_t r;
        case (o)
            MADD, MADDU: r = ACC_ADD;
            MSUB, MSUBU: r = ACC_SUB;
            default:     r = ACC_LOAD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Execute-stage multiply/divide controller: owns HI/LO, issues work to the
// external multiplier and iterative divider, accumulates MADD/MSUB results
// and stalls the pipeline until each long operation retires.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   rt,
    input  logic               flush,
    output logic               stall_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    output logic               mul_sign,
    output logic               mul_start,
    input  logic [2*WIDTH-1:0] mul_result,
    input  logic               mul_ready,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    output logic               div_sign,
    output logic               div_start,
    input  logic [WIDTH-1:0]   div_quot,
    input  logic [WIDTH-1:0]   div_rem,
    input  logic               div_ready
);

    mdu_state_t         state_r;
    mdu_state_t         state_nxt_s;
    mdu_op_t            op_r;
    logic               cancel_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    mdu_op_t            op_in_s;
    mdu_op_t            op_sel_s;
    logic               accept_s;
    logic               issue_mul_s;
    logic               issue_div_s;
    logic               drain_hold_s;
    logic [2*WIDTH-1:0] hilo_cur_s;
    logic [2*WIDTH-1:0] mul_acc_s;
    logic [2*WIDTH-1:0] hilo_nxt_s;
    logic               hilo_we_s;

    // Codes outside the enum fall through every decode helper as no-ops.
    assign op_in_s     = mdu_op_t'(op);
    assign accept_s    = (state_r == IDLE) && op_valid && !flush;
    assign issue_mul_s = accept_s && is_mul_op(op_in_s);
    assign issue_div_s = accept_s && (DIV_EN != 1'b0) && is_div_op(op_in_s);

    // While draining a cancelled divide, any op that needs the unit must wait.
    assign drain_hold_s = op_valid && (is_mul_op(op_in_s) || is_div_op(op_in_s) ||
                                       is_mt_op(op_in_s));

    // Sign selects follow the incoming op at issue and the held op afterwards.
    assign op_sel_s   = (state_r == IDLE) ? op_in_s : op_r;
    assign hilo_cur_s = {hi_r, lo_r};

    assign hi_o = hi_r;
    assign lo_o = lo_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; flush beats a same-cycle completion pulse.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_mul_s) begin
                    state_nxt_s = MUL_WAIT;
                end else if (issue_div_s) begin
                    state_nxt_s = DIV_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL_WAIT: begin
                if (flush || mul_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MUL_WAIT;
                end
            end
            DIV_WAIT: begin
                // A ready pulse coinciding with flush ends the divide outright,
                // so there is nothing left to drain.
                if (div_ready) begin
                    state_nxt_s = IDLE;
                end else if (flush) begin
                    state_nxt_s = DIV_DRAIN;
                end else begin
                    state_nxt_s = DIV_WAIT;
                end
            end
            DIV_DRAIN: begin
                if (div_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DIV_DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Pipeline stall and single-cycle start pulses.
    always_comb begin
        stall_o   = 1'b0;
        mul_start = 1'b0;
        div_start = 1'b0;
        case (state_r)
            IDLE: begin
                if (issue_mul_s) begin
                    mul_start = 1'b1;
                    stall_o   = 1'b1;
                end else if (issue_div_s) begin
                    div_start = 1'b1;
                    stall_o   = 1'b1;
                end else begin
                    stall_o   = 1'b0;
                end
            end
            MUL_WAIT: begin
                stall_o = !mul_ready;
            end
            DIV_WAIT: begin
                stall_o = !div_ready;
            end
            DIV_DRAIN: begin
                stall_o = drain_hold_s;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // Operands and signedness presented to the arithmetic units.
    always_comb begin
        if (state_r == IDLE) begin
            mul_a = rs;
            mul_b = rt;
            div_a = rs;
            div_b = rt;
        end else begin
            mul_a = {WIDTH{1'b0}};
            mul_b = {WIDTH{1'b0}};
            div_a = {WIDTH{1'b0}};
            div_b = {WIDTH{1'b0}};
        end
        mul_sign = is_mul_op(op_sel_s) && is_signed_op(op_sel_s);
        div_sign = is_div_op(op_sel_s) && is_signed_op(op_sel_s);
    end

    // Fold the product into {HI,LO}; all arithmetic wraps modulo 2^64.
    always_comb begin
        case (acc_mode(op_r))
            ACC_ADD:  mul_acc_s = hilo_cur_s + mul_result;
            ACC_SUB:  mul_acc_s = hilo_cur_s - mul_result;
            ACC_LOAD: mul_acc_s = mul_result;
            default:  mul_acc_s = mul_result;
        endcase
    end

    // HI/LO write selection: moves in IDLE, completions in the wait states.
    always_comb begin
        hilo_we_s  = 1'b0;
        hilo_nxt_s = hilo_cur_s;
        if (accept_s && (op_in_s == MTHI)) begin
            hilo_we_s  = 1'b1;
            hilo_nxt_s = {rs, lo_r};
        end else if (accept_s && (op_in_s == MTLO)) begin
            hilo_we_s  = 1'b1;
            hilo_nxt_s = {hi_r, rs};
        end else if ((state_r == MUL_WAIT) && mul_ready && !flush) begin
            hilo_we_s  = 1'b1;
            hilo_nxt_s = mul_acc_s;
        end else if ((state_r == DIV_WAIT) && div_ready && !flush && !cancel_r) begin
            // Divide-by-zero results are taken from the divider unchanged.
            hilo_we_s  = 1'b1;
            hilo_nxt_s = {div_rem, div_quot};
        end else begin
            hilo_we_s  = 1'b0;
            hilo_nxt_s = hilo_cur_s;
        end
    end

    // Operation register captured at issue, used to finish the op later.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r <= NOP;
        end else if (issue_mul_s || issue_div_s) begin
            op_r <= op_in_s;
        end else begin
            op_r <= op_r;
        end
    end

    // Cancel flag: marks an in-flight divide whose result must be discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cancel_r <= 1'b0;
        end else if ((state_r == DIV_WAIT) && flush && !div_ready) begin
            cancel_r <= 1'b1;
        end else if ((state_r == DIV_DRAIN) && div_ready) begin
            cancel_r <= 1'b0;
        end else begin
            cancel_r <= cancel_r;
        end
    end

    // Architectural HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (hilo_we_s) begin
            hi_r <= hilo_nxt_s[2*WIDTH-1:WIDTH];
            lo_r <= hilo_nxt_s[WIDTH-1:0];
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl with behavioural multiplier and divider.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int DIV_LAT = 33;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sign;
    logic        mul_start;
    logic [63:0] mul_result = 64'd0;
    logic        mul_ready = 1'b0;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_sign;
    logic        div_start;
    logic [31:0] div_quot = 32'd0;
    logic [31:0] div_rem = 32'd0;
    logic        div_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int mul_start_cnt = 0;
    int div_start_cnt = 0;
    int div_cnt = 0;
    logic [31:0] dv_a = 32'd0;
    logic [31:0] dv_b = 32'd0;
    logic        dv_s = 1'b0;

    logic [63:0] sb[$];

    mdu_ctrl #(.WIDTH(32), .DIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs(rs), .rt(rt),
        .flush(flush), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o),
        .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign), .mul_start(mul_start),
        .mul_result(mul_result), .mul_ready(mul_ready),
        .div_a(div_a), .div_b(div_b), .div_sign(div_sign), .div_start(div_start),
        .div_quot(div_quot), .div_rem(div_rem), .div_ready(div_ready)
    );

    always #5 clk = ~clk;

    // Single-cycle multiplier: product and ready pulse one cycle after start.
    always @(posedge clk) begin
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        mul_ready <= 1'b0;
        if (mul_start) begin
            sa  = {{32{mul_a[31]}}, mul_a};
            sbv = {{32{mul_b[31]}}, mul_b};
            mul_ready <= 1'b1;
            if (mul_sign) mul_result <= sa * sbv;
            else          mul_result <= {32'd0, mul_a} * {32'd0, mul_b};
        end
    end

    // Iterative divider: result visible DIV_LAT cycles after the start cycle.
    always @(posedge clk) begin
        div_ready <= 1'b0;
        if (div_start) begin
            div_cnt <= DIV_LAT - 1;
            dv_a <= div_a;
            dv_b <= div_b;
            dv_s <= div_sign;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) begin
                div_ready <= 1'b1;
                if (dv_b == 32'd0) begin
                    div_quot <= 32'hFFFF_FFFF;
                    div_rem  <= dv_a;
                end else if (dv_s) begin
                    div_quot <= $signed(dv_a) / $signed(dv_b);
                    div_rem  <= $signed(dv_a) % $signed(dv_b);
                end else begin
                    div_quot <= dv_a / dv_b;
                    div_rem  <= dv_a % dv_b;
                end
            end
        end
    end

    // Start-pulse counters.
    always @(posedge clk) begin
        if (mul_start) mul_start_cnt <= mul_start_cnt + 1;
        if (div_start) div_start_cnt <= div_start_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_stall;
        int          exp_mul;
        int          exp_div;
    } vec_t;

    // Drive one op, wait out its stall, retire it and score the result.
    task automatic run_vec(input vec_t v, input int idx);
        int stalls;
        int ms0;
        int ds0;
        logic [63:0] exp;
        ms0 = mul_start_cnt;
        ds0 = div_start_cnt;
        sb.push_back({v.exp_hi, v.exp_lo});
        @(negedge clk);
        op_valid = 1'b1; op = v.op; rs = v.rs; rt = v.rt;
        stalls = 0;
        #1;
        while (stall_o && stalls < TIMEOUT) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= TIMEOUT) check($sformatf("timeout[%0d]", idx), 64'd1, 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = NOP;
        exp = sb.pop_front();
        check($sformatf("hi[%0d]", idx), {32'd0, hi_o}, {32'd0, exp[63:32]});
        check($sformatf("lo[%0d]", idx), {32'd0, lo_o}, {32'd0, exp[31:0]});
        check($sformatf("stall[%0d]", idx), 64'(stalls), 64'(v.exp_stall));
        check($sformatf("mulpulse[%0d]", idx), 64'(mul_start_cnt - ms0), 64'(v.exp_mul));
        check($sformatf("divpulse[%0d]", idx), 64'(div_start_cnt - ds0), 64'(v.exp_div));
    endtask

    vec_t tbl[14];

    initial begin
        int stalls;
        logic lo_disturbed;

        tbl[0]  = '{MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1,  1, 0};
        tbl[1]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1,  1, 0};
        tbl[2]  = '{MTLO,  32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFE, 32'hFFFF_FFFF, 0,  0, 0};
        tbl[3]  = '{MTHI,  32'd0,         32'd0,        32'h0000_0000, 32'hFFFF_FFFF, 0,  0, 0};
        tbl[4]  = '{MADDU, 32'd1,         32'd1,        32'h0000_0001, 32'h0000_0000, 1,  1, 0};
        tbl[5]  = '{MSUB,  32'd1,         32'd1,        32'h0000_0000, 32'hFFFF_FFFF, 1,  1, 0};
        tbl[6]  = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 0, 1};
        tbl[7]  = '{DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 33, 0, 1};
        tbl[8]  = '{NOP,   32'd9,         32'd9,        32'h0000_0002, 32'h0000_000E, 0,  0, 0};
        tbl[9]  = '{4'hF,  32'd9,         32'd9,        32'h0000_0002, 32'h0000_000E, 0,  0, 0};
        tbl[10] = '{MADD,  32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'h0000_0008, 1,  1, 0};
        tbl[11] = '{MSUBU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0000, 32'h0000_000A, 1,  1, 0};
        tbl[12] = '{DIV,   32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 33, 0, 1};
        tbl[13] = '{MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0004, 32'h0000_0000, 1,  1, 0};

        rst = 1'b1; op_valid = 1'b0; op = NOP; rs = 32'd0; rt = 32'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", {32'd0, hi_o}, 64'd0);
        check("rst_lo", {32'd0, lo_o}, 64'd0);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_mulstart", {63'd0, mul_start}, 64'd0);
        check("rst_divstart", {63'd0, div_start}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        // Flushed divide: drain, hold a following MULT, never write the quotient.
        @(negedge clk);
        op_valid = 1'b1; op = DIV; rs = 32'd9; rt = 32'd2;
        repeat (4) @(negedge clk);
        op_valid = 1'b0; op = NOP; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("drain_stall_drop", {63'd0, stall_o}, 64'd0);
        op_valid = 1'b1; op = MULT; rs = 32'd3; rt = 32'd4;
        stalls = 0;
        lo_disturbed = 1'b0;
        #1;
        while (stall_o && stalls < TIMEOUT) begin
            stalls++;
            if (lo_o !== tbl[13].exp_lo || hi_o !== tbl[13].exp_hi) lo_disturbed = 1'b1;
            @(negedge clk);
            #1;
        end
        check("drain_stall_cycles", 64'(stalls), 64'd30);
        check("drain_no_write", {63'd0, lo_disturbed}, 64'd0);
        @(posedge clk);
        #1;
        op_valid = 1'b0; op = NOP;
        check("drain_mult_hi", {32'd0, hi_o}, 64'd0);
        check("drain_mult_lo", {32'd0, lo_o}, 64'd12);

        // Flush coinciding with mul_ready: flush wins, HI/LO untouched.
        @(negedge clk);
        op_valid = 1'b1; op = MULT; rs = 32'd7; rt = 32'd7;
        @(negedge clk);
        op_valid = 1'b0; op = NOP; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("mulflush_hi", {32'd0, hi_o}, 64'd0);
        check("mulflush_lo", {32'd0, lo_o}, 64'd12);

        // Reset during MUL_WAIT with mul_ready in the same cycle.
        @(negedge clk);
        op_valid = 1'b1; op = MULT; rs = 32'd2; rt = 32'd3;
        @(negedge clk);
        op_valid = 1'b0; op = NOP; rst = 1'b1;
        @(posedge clk);
        #1;
        check("mulrst_hi", {32'd0, hi_o}, 64'd0);
        check("mulrst_lo", {32'd0, lo_o}, 64'd0);
        check("mulrst_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec('{MTLO, 32'h55, 32'd0, 32'd0, 32'h55, 0, 0, 0}, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
